hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage core. It produces the stall (`en`, active-high stall) and flush (`clear`) controls for the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage operand forwarding selects. It sits beside the datapath and consumes the register indices and control bits the pipeline registers carry. It also sequences a multi-cycle multiply/divide stall with an internal FSM and down-counter.

---
 rtl/hazard_unit.sv | 106 ++++++++++
 tb/tb_hazard_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use stall, branch flush,
// and a multi-cycle mul/div stall sequencer compiled in when MULDIV_STALL_EN is defined.
module hazard_unit #(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_rt_used,
  input  logic       D_branch_taken,
  input  logic [4:0] E_rs,
  input  logic [4:0] E_rt,
  input  logic [4:0] E_wreg,
  input  logic       E_w_reg_ena,
  input  logic       E_mem_r,
  input  logic       E_md_start,
  input  logic [4:0] M_wreg,
  input  logic       M_w_reg_ena,
  input  logic [4:0] W_wreg,
  input  logic       W_w_reg_ena,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_m,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       md_busy,
  output logic       md_done
);

`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  // Without the feature the start pulse is masked, so the FSM never leaves IDLE.
  localparam bit MD_EN = 1'b0;
`endif

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 2);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy, lu;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_wreg, input logic m_ena,
    input logic [4:0] w_wreg, input logic w_ena
  );
    if (m_ena && (m_wreg != 5'd0) && (m_wreg == src))      return 2'b10;
    else if (w_ena && (w_wreg != 5'd0) && (w_wreg == src)) return 2'b01;
    else                                                   return 2'b00;
  endfunction

  assign fwd_a_sel = fwd_sel(E_rs, M_wreg, M_w_reg_ena, W_wreg, W_w_reg_ena);
  assign fwd_b_sel = fwd_sel(E_rt, M_wreg, M_w_reg_ena, W_wreg, W_w_reg_ena);

  assign lu = E_mem_r && E_w_reg_ena && (E_wreg != 5'd0) &&
              ((E_wreg == D_rs) || (D_rt_used && (E_wreg == D_rt)));

  assign busy = (state == BUSY);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      if (MD_EN && E_md_start) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_LOAD;
      end
    end else if (cnt == '0) begin
      state_nxt = IDLE;
    end else begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: mul/div BUSY over load-use over branch flush.
  assign stall_if = busy || lu;
  assign stall_id = busy || lu;
  assign stall_ex = busy;
  assign flush_m  = busy;
  assign flush_ex = !busy && lu;
  assign flush_id = !busy && !lu && D_branch_taken;
  assign md_busy  = busy;
  assign md_done  = busy && (cnt == '0);

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized cycles against a
// behavioural model that tracks the mul/div as a count of remaining busy cycles.
module tb_hazard_unit;

  localparam int MD_CYCLES = 4;
`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, E_wreg, M_wreg, W_wreg;
  logic       D_rt_used, D_branch_taken, E_w_reg_ena, E_mem_r, E_md_start;
  logic       M_w_reg_ena, W_w_reg_ena;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_m;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       md_busy, md_done;
  logic [11:0] outs;

  int checks = 0;
  int errors = 0;
  int md_left = 0;

  hazard_unit #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .D_rs(D_rs), .D_rt(D_rt), .D_rt_used(D_rt_used), .D_branch_taken(D_branch_taken),
    .E_rs(E_rs), .E_rt(E_rt), .E_wreg(E_wreg), .E_w_reg_ena(E_w_reg_ena),
    .E_mem_r(E_mem_r), .E_md_start(E_md_start),
    .M_wreg(M_wreg), .M_w_reg_ena(M_w_reg_ena), .W_wreg(W_wreg), .W_w_reg_ena(W_w_reg_ena),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_m(flush_m),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  assign outs = {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_m,
                 fwd_a_sel, fwd_b_sel, md_busy, md_done};

  // Reference model: md remaining busy cycles plus the hazard rules on the current inputs.
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (M_w_reg_ena && M_wreg != 0 && M_wreg == src) return 2'd2;
    if (W_w_reg_ena && W_wreg != 0 && W_wreg == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [11:0] model_outs(input int left);
    bit busy, load_use;
    busy     = (left > 0);
    load_use = E_mem_r && E_w_reg_ena && E_wreg != 0 &&
               (E_wreg == D_rs || (D_rt_used && E_wreg == D_rt));
    return {busy || load_use, busy || load_use, busy,
            D_branch_taken && !busy && !load_use, load_use && !busy, busy,
            ref_fwd(E_rs), ref_fwd(E_rt), busy, left == 1};
  endfunction

  task automatic idle_inputs();
    {D_rs, D_rt, E_rs, E_rt, E_wreg, M_wreg, W_wreg} = '0;
    {D_rt_used, D_branch_taken, E_w_reg_ena, E_mem_r, E_md_start} = '0;
    {M_w_reg_ena, W_w_reg_ena} = '0;
  endtask

  task automatic random_inputs();
    D_rs = 5'($urandom_range(0, 3));   D_rt = 5'($urandom_range(0, 3));
    E_rs = 5'($urandom_range(0, 3));   E_rt = 5'($urandom_range(0, 3));
    E_wreg = 5'($urandom_range(0, 3)); M_wreg = 5'($urandom_range(0, 3));
    W_wreg = 5'($urandom_range(0, 3));
    D_rt_used = 1'($urandom);  D_branch_taken = 1'($urandom_range(0, 3) == 0);
    E_w_reg_ena = 1'($urandom); E_mem_r = 1'($urandom_range(0, 2) == 0);
    M_w_reg_ena = 1'($urandom); W_w_reg_ena = 1'($urandom);
    E_md_start = 1'($urandom_range(0, 7) == 0);
  endtask

  // Clock edge: the model consumes the inputs seen in the cycle just ending.
  task automatic advance();
    @(posedge clk);
    if (md_left > 0) md_left--;
    else if (MD_EN && E_md_start) md_left = MD_CYCLES - 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 12'd0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", outs, 12'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    md_left = 0;
  endtask

  task automatic test_forwarding();
    idle_inputs();
    E_rs = 5; M_wreg = 5; M_w_reg_ena = 1; W_wreg = 5; W_w_reg_ena = 1;
    @(negedge clk); checks++;
    if (fwd_a_sel !== 2'b10 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL fwd_mem_priority: got fwd_a=%b outs=%b expected fwd_a=10 outs=%b",
                         fwd_a_sel, outs, model_outs(md_left));
    end
    advance();
    M_w_reg_ena = 0;
    @(negedge clk); checks++;
    if (fwd_a_sel !== 2'b01 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL fwd_wb: got fwd_a=%b expected 01", fwd_a_sel);
    end
    advance();
    E_rs = 0; M_wreg = 0; W_wreg = 0; M_w_reg_ena = 1; E_rt = 9; W_wreg = 9;
    @(negedge clk); checks++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b01 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL fwd_r0_and_b: got fwd_a=%b fwd_b=%b expected 00 01",
                         fwd_a_sel, fwd_b_sel);
    end
    advance();
    for (int i = 0; i < 40; i++) begin
      random_inputs(); E_md_start = 0;
      @(negedge clk); checks++;
      if (outs !== model_outs(md_left)) begin
        errors++; $display("FAIL fwd_random[%0d]: got %b expected %b", i, outs, model_outs(md_left));
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    E_mem_r = 1; E_w_reg_ena = 1; E_wreg = 8; D_rt = 8; D_rt_used = 1; D_rs = 3;
    @(negedge clk); checks++;
    if ({stall_if, stall_id, flush_ex, stall_ex} !== 4'b1110 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL load_use_stall: got %b expected %b", outs, model_outs(md_left));
    end
    advance();
    // Load has moved to MEM; the dependent instruction is in EX reading rt.
    idle_inputs();
    M_wreg = 8; M_w_reg_ena = 1; E_rt = 8; E_rs = 3;
    @(negedge clk); checks++;
    if ({stall_if, stall_id, flush_ex} !== 3'b000 || fwd_b_sel !== 2'b10) begin
      errors++; $display("FAIL load_use_release: got stalls=%b fwd_b=%b expected 000 10",
                         {stall_if, stall_id, flush_ex}, fwd_b_sel);
    end
    advance();
    idle_inputs();
    E_mem_r = 1; E_w_reg_ena = 1; E_wreg = 8; D_rt = 8; D_rt_used = 0; D_rs = 3;
    @(negedge clk); checks++;
    if ({stall_if, stall_id, flush_ex} !== 3'b000 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL load_use_rt_unused: got %b expected %b", outs, model_outs(md_left));
    end
    advance();
  endtask

  task automatic test_branch();
    idle_inputs();
    D_branch_taken = 1;
    @(negedge clk); checks++;
    if (flush_id !== 1'b1 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL branch_flush: got flush_id=%b expected 1", flush_id);
    end
    advance();
    E_mem_r = 1; E_w_reg_ena = 1; E_wreg = 4; D_rs = 4;
    @(negedge clk); checks++;
    if (flush_id !== 1'b0 || stall_id !== 1'b1 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL branch_vs_lu: got flush_id=%b stall_id=%b expected 0 1",
                         flush_id, stall_id);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      @(negedge clk); checks++;
      if (outs !== model_outs(md_left)) begin
        errors++; $display("FAIL random[%0d]: got %b expected %b", i, outs, model_outs(md_left));
      end
      advance();
    end
    idle_inputs();
    repeat (MD_CYCLES) advance();
  endtask

`ifdef MULDIV_STALL_EN
  task automatic test_muldiv();
    idle_inputs();
    E_md_start = 1;
    @(negedge clk); checks++;
    if (md_busy !== 1'b0 || stall_ex !== 1'b0) begin
      errors++; $display("FAIL md_start_cycle: got busy=%b stall_ex=%b expected 0 0", md_busy, stall_ex);
    end
    advance();
    E_md_start = 0;
    for (int i = 1; i < MD_CYCLES; i++) begin
      E_md_start = (i == 2);
      @(negedge clk); checks++;
      if (md_busy !== 1'b1 || stall_ex !== 1'b1 || flush_m !== 1'b1 ||
          md_done !== (i == MD_CYCLES - 1) || outs !== model_outs(md_left)) begin
        errors++; $display("FAIL md_busy_cycle[%0d]: got %b expected %b", i, outs, model_outs(md_left));
      end
      advance();
    end
    E_md_start = 0;
    @(negedge clk); checks++;
    if (outs !== 12'd0) begin
      errors++; $display("FAIL md_after: got %b expected %b", outs, 12'd0);
    end
    advance();
  endtask

  task automatic test_priority();
    idle_inputs();
    E_md_start = 1;
    advance();
    E_md_start = 0;
    E_mem_r = 1; E_w_reg_ena = 1; E_wreg = 6; D_rs = 6; D_branch_taken = 1;
    for (int i = 1; i < MD_CYCLES; i++) begin
      @(negedge clk); checks++;
      if (flush_ex !== 1'b0 || flush_id !== 1'b0 || stall_if !== 1'b1 || outs !== model_outs(md_left)) begin
        errors++; $display("FAIL prio_busy[%0d]: got %b expected %b", i, outs, model_outs(md_left));
      end
      advance();
    end
    @(negedge clk); checks++;
    if ({stall_id, flush_ex, flush_id, stall_ex} !== 4'b1100 || outs !== model_outs(md_left)) begin
      errors++; $display("FAIL prio_lu_after_busy: got %b expected %b", outs, model_outs(md_left));
    end
    advance();
  endtask

  task automatic test_reset_mid_busy();
    int busy_cnt, done_cnt;
    idle_inputs();
    E_md_start = 1;
    advance();
    E_md_start = 0;
    advance();
    #2 rst = 1'b0;
    md_left = 0;
    #1; checks++;
    if (outs !== 12'd0) begin
      errors++; $display("FAIL reset_mid_busy: got %b expected %b", outs, 12'd0);
    end
    repeat (2) begin
      @(negedge clk); checks++;
      if (md_done !== 1'b0 || md_busy !== 1'b0) begin
        errors++; $display("FAIL reset_hold: got busy=%b done=%b expected 0 0", md_busy, md_done);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    E_md_start = 1;
    advance();
    E_md_start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < MD_CYCLES + 4; i++) begin
      @(negedge clk);
      busy_cnt += int'(md_busy);
      done_cnt += int'(md_done);
      advance();
    end
    checks++;
    if (busy_cnt != MD_CYCLES - 1 || done_cnt != 1) begin
      errors++; $display("FAIL md_after_reset: got busy=%0d done=%0d expected busy=%0d done=1",
                         busy_cnt, done_cnt, MD_CYCLES - 1);
    end
  endtask
`else
  task automatic test_md_disabled();
    idle_inputs();
    E_md_start = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); checks++;
      if ({md_busy, md_done, stall_ex, flush_m} !== 4'b0000 || outs !== model_outs(md_left)) begin
        errors++; $display("FAIL md_disabled[%0d]: got %b expected %b", i, outs, model_outs(md_left));
      end
      advance();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
`ifdef MULDIV_STALL_EN
    test_muldiv();
    test_priority();
    test_reset_mid_busy();
`else
    test_md_disabled();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
